// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO read port into a valid/ready
// stream through a 2-entry skid buffer that hides the 1-cycle read latency.
// Ports: clk, rst_n (async, active-low), en (read enable);
//   FIFO side  : fifo_r_en (out), fifo_rdata, fifo_rempty (in);
//   stream side: m_valid, m_data (out), m_ready (in);
//   status     : rd_cnt (words delivered, wrapping), busy.
module fifo_rd_stream #(
    parameter int DATASIZE = 8,
    parameter int CNTSIZE  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                fifo_r_en,
    input  logic [DATASIZE-1:0] fifo_rdata,
    input  logic                fifo_rempty,
    output logic                m_valid,
    output logic [DATASIZE-1:0] m_data,
    input  logic                m_ready,
    output logic [CNTSIZE-1:0]  rd_cnt,
    output logic                busy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                occ;
    occ_t                occ_nxt;
    logic                pend;
    logic [DATASIZE-1:0] buf0;
    logic [DATASIZE-1:0] buf1;
    logic [DATASIZE-1:0] buf0_nxt;
    logic [DATASIZE-1:0] buf1_nxt;
    logic                pop;
    logic                cap;
    logic [2:0]          held_sum;

    assign pop = m_valid && m_ready;
    assign cap = pend;

    // Words the buffer will hold after this edge before any new read:
    // a new read is only safe if that leaves a free slot for its data.
    assign held_sum = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};

    assign fifo_r_en = rst_n && en && !fifo_rempty && (held_sum < 3'd2);

    assign m_valid = (occ != EMPTY);
    assign m_data  = buf0;
    assign busy    = (occ != EMPTY) || pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= EMPTY;
            pend   <= 1'b0;
            buf0   <= '0;
            buf1   <= '0;
            rd_cnt <= '0;
        end else begin
            occ  <= occ_nxt;
            pend <= fifo_r_en && !fifo_rempty;
            buf0 <= buf0_nxt;
            buf1 <= buf1_nxt;
            if (pop) begin
                rd_cnt <= rd_cnt + CNTSIZE'(1);
            end
        end
    end

    always_comb begin
        occ_nxt  = occ;
        buf0_nxt = buf0;
        buf1_nxt = buf1;
        unique case (occ)
            EMPTY: begin
                if (cap) begin
                    occ_nxt  = ONE;
                    buf0_nxt = fifo_rdata;
                end
            end
            ONE: begin
                if (pop && cap) begin
                    buf0_nxt = fifo_rdata;
                end else if (pop) begin
                    occ_nxt = EMPTY;
                end else if (cap) begin
                    occ_nxt  = TWO;
                    buf1_nxt = fifo_rdata;
                end
            end
            TWO: begin
                // No capture can land here: the issue rule withholds
                // the read that would have produced it.
                if (pop) begin
                    occ_nxt  = ONE;
                    buf0_nxt = buf1;
                end
            end
            default: begin
                occ_nxt = EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: drives fifo_rd_stream from a behavioural 16-deep FIFO
// and checks the stream against the FIFO write order.
module tb_fifo_rd_stream;

    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 16;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          en       = 1'b0;
    logic          m_ready  = 1'b0;
    logic          wr_en    = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          fifo_clr = 1'b0;

    logic          fifo_r_en;
    logic          m_valid;
    logic          busy;
    logic [DW-1:0] m_data;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rempty;
    logic [CW-1:0] rd_cnt;

    logic          fifo_r_en_s;
    logic          m_valid_s;
    logic          busy_s;
    logic [DW-1:0] m_data_s;
    logic [2:0]    rd_cnt_s;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got[$];

    int held  = 0;
    bit ovf   = 1'b0;
    int tests = 0;
    int fails = 0;
    int pops  = 0;

    bit rd_acc;
    bit wr_acc;
    bit pp;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATASIZE(DW), .CNTSIZE(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .fifo_r_en   (fifo_r_en),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .rd_cnt      (rd_cnt),
        .busy        (busy)
    );

    // Narrow-counter copy on identical inputs, to exercise the wrap.
    fifo_rd_stream #(.DATASIZE(DW), .CNTSIZE(3)) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .fifo_r_en   (fifo_r_en_s),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .m_valid     (m_valid_s),
        .m_data      (m_data_s),
        .m_ready     (m_ready),
        .rd_cnt      (rd_cnt_s),
        .busy        (busy_s)
    );

    // Behavioural FIFO plus a count of words owned by the adapter.
    always @(posedge clk or posedge fifo_clr) begin
        if (fifo_clr) begin
            fq.delete();
            exp_q.delete();
            fifo_rempty <= 1'b1;
            fifo_rdata  <= '0;
        end else begin
            rd_acc = fifo_r_en && (fq.size() > 0);
            wr_acc = wr_en && (fq.size() < DEPTH);
            pp     = m_valid && m_ready;
            if (rd_acc) fifo_rdata <= fq.pop_front();
            if (wr_acc) begin
                fq.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            fifo_rempty <= (fq.size() == 0);
            if (!rst_n) begin
                held = 0;
            end else begin
                held = held + int'(rd_acc) - int'(pp);
                if (held > 2) ovf = 1'b1;
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic w,
                       input logic [DW-1:0] d);
        @(negedge clk);
        m_ready = r;
        en      = e;
        wr_en   = w;
        wr_data = d;
        #1;
        if (m_valid && m_ready) begin
            got.push_back(m_data);
            pops++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        en       = 1'b0;
        m_ready  = 1'b0;
        wr_en    = 1'b0;
        fifo_clr = 1'b1;
        #1 fifo_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        pops = 0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] w;
        for (int i = 0; i < 3; i++) begin
            w = DW'(8'hA0 + i);
            cyc(1'b1, 1'b1, 1'b1, w);
            tests++;
            if (fifo_r_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 ||
                rd_cnt !== '0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: r_en=%b valid=%b data=%h cnt=%0d busy=%b, want all 0",
                         i, fifo_r_en, m_valid, m_data, rd_cnt, busy);
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        #1;
        tests++;
        if (fifo_r_en !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: r_en=%b want 1", fifo_r_en);
        end
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, '0);
        tests++;
        if (got.size() != 3) begin
            fails++;
            $display("FAIL reset_words: got %0d words want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                w = DW'(8'hA0 + i);
                tests++;
                if (got[i] !== w) begin
                    fails++;
                    $display("FAIL reset_data[%0d]: got %h want %h", i, got[i], w);
                end
            end
        end
        tests++;
        if (rd_cnt !== CW'(3) || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_cnt: cnt=%0d busy=%b want 3/0", rd_cnt, busy);
        end
    endtask

    task automatic test_streaming();
        int first_ren = -1;
        int first_val = -1;
        int gaps      = 0;
        do_reset();
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 1'b1, DW'(i));
        for (int c = 0; c < 24; c++) begin
            cyc(1'b1, 1'b1, 1'b0, '0);
            if (fifo_r_en && first_ren < 0) first_ren = c;
            if (m_valid && first_val < 0) first_val = c;
            if (c < 16 && !fifo_r_en) gaps++;
            if (first_val >= 0 && c < first_val + 16 && !m_valid) gaps++;
        end
        tests++;
        if (first_ren != 0 || first_val - first_ren != 2) begin
            fails++;
            $display("FAIL stream_latency: first r_en %0d first valid %0d, want 0 and 2",
                     first_ren, first_val);
        end
        tests++;
        if (gaps != 0) begin
            fails++;
            $display("FAIL stream_gaps: %0d idle cycles want 0", gaps);
        end
        tests++;
        if (got.size() != 16) begin
            fails++;
            $display("FAIL stream_count: got %0d words want 16", got.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                tests++;
                if (got[i] !== DW'(i)) begin
                    fails++;
                    $display("FAIL stream_data[%0d]: got %h want %h", i, got[i], DW'(i));
                end
            end
        end
        tests++;
        if (rd_cnt !== CW'(16)) begin
            fails++;
            $display("FAIL stream_cnt: got %0d want 16", rd_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, DW'(8'h10 + i));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, '0);
        tests++;
        if (got.size() != 1) begin
            fails++;
            $display("FAIL bp_first: got %0d words want 1", got.size());
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            tests++;
            if (fifo_r_en !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h11) begin
                fails++;
                $display("FAIL bp_stall[%0d]: r_en=%b valid=%b data=%h want 0/1/11",
                         i, fifo_r_en, m_valid, m_data);
            end
        end
        tests++;
        if (held != 2) begin
            fails++;
            $display("FAIL bp_occ_two: held %0d want 2", held);
        end
        cyc(1'b1, 1'b1, 1'b0, '0);
        tests++;
        if (fifo_r_en !== 1'b1) begin
            fails++;
            $display("FAIL bp_resume: r_en=%b want 1", fifo_r_en);
        end
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, '0);
        tests++;
        if (got.size() != 5) begin
            fails++;
            $display("FAIL bp_count: got %0d words want 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (got[i] !== DW'(8'h10 + i)) begin
                    fails++;
                    $display("FAIL bp_data[%0d]: got %h want %h", i, got[i], DW'(8'h10 + i));
                end
            end
        end
    endtask

    task automatic test_enable();
        int viol = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b1, DW'(8'h40 + i));
            if (fifo_r_en !== 1'b0 || m_valid !== 1'b0) viol++;
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0);
            if (fifo_r_en !== 1'b0 || m_valid !== 1'b0) viol++;
        end
        tests++;
        if (viol != 0) begin
            fails++;
            $display("FAIL en_gate: %0d active cycles want 0", viol);
        end
        cyc(1'b1, 1'b1, 1'b0, '0);
        tests++;
        if (fifo_r_en !== 1'b1) begin
            fails++;
            $display("FAIL en_pulse: r_en=%b want 1", fifo_r_en);
        end
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        tests++;
        if (got.size() != 1 || got[0] !== 8'h40) begin
            fails++;
            $display("FAIL en_one_word: got %0d words first %h want 1 word 40",
                     got.size(), (got.size() > 0) ? got[0] : 8'h00);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, DW'(8'h20 + i));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0);
        @(posedge clk);
        #2;
        tests++;
        if (m_valid !== 1'b1 || busy !== 1'b1 || rd_cnt !== CW'(1) || held != 2) begin
            fails++;
            $display("FAIL mid_pre: valid=%b busy=%b cnt=%0d held=%0d want 1/1/1/2",
                     m_valid, busy, rd_cnt, held);
        end
        rst_n    = 1'b0;
        fifo_clr = 1'b1;
        #1;
        fifo_clr = 1'b0;
        tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || rd_cnt !== '0 || fifo_r_en !== 1'b0) begin
            fails++;
            $display("FAIL mid_async: valid=%b busy=%b cnt=%0d r_en=%b want all 0",
                     m_valid, busy, rd_cnt, fifo_r_en);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        pops = 0;
    endtask

    task automatic test_soak();
        logic [DW-1:0] a;
        logic [DW-1:0] e;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                $urandom_range(0, 1) == 1, DW'($urandom));
            while (got.size() > 0) begin
                a = got.pop_front();
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL soak_extra: got %h with nothing expected", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        fails++;
                        $display("FAIL soak_data[%0d]: got %h want %h", pops, a, e);
                    end
                end
            end
        end
        cyc(1'b0, 1'b0, 1'b0, '0);
        tests++;
        if (rd_cnt !== CW'(pops)) begin
            fails++;
            $display("FAIL soak_cnt: got %0d want %0d", rd_cnt, CW'(pops));
        end
        tests++;
        if (rd_cnt_s !== 3'(pops)) begin
            fails++;
            $display("FAIL soak_cnt_wrap: got %0d want %0d", rd_cnt_s, 3'(pops));
        end
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL overflow: buffer held more than 2 words");
        end
    endtask

    initial begin
        #1 fifo_clr = 1'b1;
        #1 fifo_clr = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_enable();
        test_midreset();
        test_soak();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
